comb_sweep_ctrl: RTL and testbench
==================================

Name: comb_sweep_ctrl

Overview:
Sequencer that drives the 5-input combinational selector block (inputs sel, A, B, C, D; output y) through all 32 input combinations.
- Holds each vector for a programmable settle time, then samples y into a 32-bit captured truth table.
- Compares every sample against a golden table and reports a mismatch count plus pass/fail.
- Sits beside the combinational block as its self-test / characterisation controller, started by a single-cycle request.

Parameters:
SETTLE_CYC, 1, cycles a vector is held before the sample cycle; legal range 0..15.
EXPECT, 32'h0000_0000, golden truth table; bit i is the expected y for vector index i.

Ports:
clk  in  1  system clock; all state changes on rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  sweep request; sampled only in IDLE.
sel  out  1  drive to block sel; equals idx[4].
A  out  1  drive to block A; equals idx[3].
B  out  1  drive to block B; equals idx[2].
C  out  1  drive to block C; equals idx[1].
D  out  1  drive to block D; equals idx[0].
y  in  1  block output under test.
busy  out  1  high while a sweep is in progress (SETTLE or SAMPLE).
done  out  1  one-cycle pulse when the sweep completes.
result  out  32  captured truth table; bit i is y sampled for vector i.
err_cnt  out  6  number of vectors where y != EXPECT[i]; range 0..32.
pass  out  1  high when the last sweep completed with err_cnt == 0.

Behaviour:
- Reset: state=IDLE, idx=0, settle counter=0, so sel/A/B/C/D=0. busy=0, done=0, result=0, err_cnt=0, pass=0.
- Internal 5-bit idx register drives outputs directly as {sel,A,B,C,D}. Outputs are glitch-free registered values.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE, with start=1 at edge k:
  - idx<=0, result<=0, err_cnt<=0, pass<=0, counter<=SETTLE_CYC.
  - Go to SETTLE if SETTLE_CYC>0, else directly to SAMPLE.
- SETTLE: counter decrements each edge. When counter==1, go to SAMPLE. Vector held constant.
- SAMPLE: at the edge ending this cycle:
  - result[idx]<=y.
  - If y!=EXPECT[idx], err_cnt<=err_cnt+1.
  - If idx==31: go to DONE and set idx<=0.
  - Otherwise: idx<=idx+1, reload counter, go to SETTLE (or SAMPLE again if SETTLE_CYC==0).
- Timing: each vector occupies exactly SETTLE_CYC+1 cycles. The last sample is taken at edge k+32*(SETTLE_CYC+1).
- DONE: lasts one cycle.
  - done=1 during this cycle, visible after edge k+32*(SETTLE_CYC+1).
  - pass=1 if the final err_cnt (including the last sample) is 0; pass is registered on entry to DONE.
  - Next state is IDLE.
- busy=1 exactly in SETTLE and SAMPLE.
- result, err_cnt and pass hold their values in IDLE until the next accepted start.
- start is ignored in SETTLE/SAMPLE/DONE. No queuing; a start held high is accepted again in the first IDLE cycle after DONE.
- err_cnt never wraps: max 32 fits in 6 bits.
- Reset mid-sweep: all registers return to reset values at that edge. No done pulse; partial result is discarded (0).
- rst has priority over start on the same edge.

Test Plan:
1. Reset: hold rst 2 cycles, start=0 -> all outputs 0, busy=0, state stays IDLE for 10 cycles.
2. SETTLE_CYC=1, EXPECT=32'hF0F0_CCAA, bench models y=EXPECT[{sel,A,B,C,D}]; start pulse at edge k -> busy high edges k..k+63, done pulse after edge k+64, result=32'hF0F0_CCAA, err_cnt=0, pass=1.
3. Same EXPECT, y tied to 0 -> result=0, err_cnt=16, pass=0, done still after edge k+64.
4. start pulses at cycles 5, 20 and 40 after the first accepted start -> only one sweep; exactly one done pulse; vector sequence 0..31 uninterrupted, each held 2 cycles.
5. rst asserted while idx=10 -> next cycle sel/A..D=0, busy=0, result=0, err_cnt=0; no done pulse; a new start runs a full clean sweep.
6. SETTLE_CYC=0, y=D (bench model), EXPECT=32'hAAAA_AAAA -> done after edge k+32, result=32'hAAAA_AAAA, err_cnt=0, pass=1. Vectors advance every cycle.

Source files
------------

// File: rtl/comb_sweep_ctrl.sv
// Self-test sequencer for the 5-input selector block: walks all 32 input
// vectors, samples y after a settle window, and scores it against a golden table.
module comb_sweep_ctrl #(
    parameter int unsigned SETTLE_CYC = 1,
    parameter logic [31:0] EXPECT     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        sel,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    input  logic        y,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [5:0]  err_cnt,
    output logic        pass
);

    localparam int unsigned IDX_W = 5;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned ERR_W = 6;
    localparam int unsigned TT_W  = 32;

    localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(SETTLE_CYC);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TT_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // With no settle window each vector is sampled in its first cycle.
    localparam state_t FIRST_ST = (SETTLE_CYC > 0) ? SETTLE : SAMPLE;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [TT_W-1:0]    result_nxt;
    logic [ERR_W-1:0]   err_nxt;
    logic               pass_nxt;
    logic               busy_nxt;
    logic               done_nxt;

    // The vector register drives the block directly, so its inputs never glitch.
    assign {sel, A, B, C, D} = idx;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            cnt     <= '0;
            result  <= '0;
            err_cnt <= '0;
            pass    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            cnt     <= cnt_nxt;
            result  <= result_nxt;
            err_cnt <= err_nxt;
            pass    <= pass_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        cnt_nxt    = cnt;
        result_nxt = result;
        err_nxt    = err_cnt;
        pass_nxt   = pass;

        case (state)
            IDLE: begin
                if (start) begin
                    idx_nxt    = '0;
                    result_nxt = '0;
                    err_nxt    = '0;
                    pass_nxt   = 1'b0;
                    cnt_nxt    = RELOAD;
                    state_nxt  = FIRST_ST;
                end
            end
            SETTLE: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                result_nxt[idx] = y;
                if (y != EXPECT[idx]) begin
                    err_nxt = err_cnt + ERR_W'(1);
                end
                if (idx == LAST_IDX) begin
                    idx_nxt   = '0;
                    pass_nxt  = (err_nxt == '0);
                    state_nxt = DONE;
                end else begin
                    idx_nxt   = idx + IDX_W'(1);
                    cnt_nxt   = RELOAD;
                    state_nxt = FIRST_ST;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt == SETTLE) || (state_nxt == SAMPLE);
        done_nxt = (state_nxt == DONE);
    end

endmodule

// File: tb/tb_comb_sweep_ctrl.sv
// Scoreboarded bench for comb_sweep_ctrl: one instance with a 1-cycle settle
// window and one with none, each driving a bench model of the selector block.
module tb_comb_sweep_ctrl;

    localparam logic [31:0] EXP0 = 32'hF0F0_CCAA;
    localparam logic [31:0] EXP1 = 32'hAAAA_AAAA;

    typedef struct {
        logic [31:0] res;
        logic [5:0]  err;
        logic        pass;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start1;
    logic        sel0, a0, b0, c0, d0, y0, busy0, done0, pass0;
    logic        sel1, a1, b1, c1, d1, y1, busy1, done1, pass1;
    logic [31:0] result0, result1;
    logic [5:0]  err0, err1;
    logic        y0_zero;
    logic [31:0] exp0_v;

    logic [4:0]  idx0, idx1;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign idx0   = {sel0, a0, b0, c0, d0};
    assign idx1   = {sel1, a1, b1, c1, d1};
    assign exp0_v = EXP0;
    assign y0     = y0_zero ? 1'b0 : exp0_v[idx0];
    assign y1     = d1;

    comb_sweep_ctrl #(.SETTLE_CYC(1), .EXPECT(EXP0)) u0 (
        .clk(clk), .rst(rst), .start(start0),
        .sel(sel0), .A(a0), .B(b0), .C(c0), .D(d0), .y(y0),
        .busy(busy0), .done(done0), .result(result0), .err_cnt(err0), .pass(pass0)
    );

    comb_sweep_ctrl #(.SETTLE_CYC(0), .EXPECT(EXP1)) u1 (
        .clk(clk), .rst(rst), .start(start1),
        .sel(sel1), .A(a1), .B(b1), .C(c1), .D(d1), .y(y1),
        .busy(busy1), .done(done1), .result(result1), .err_cnt(err1), .pass(pass1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected sweep.
    always @(negedge clk) begin
        exp_t e;
        if (done0) begin
            check("done0_pending", 64'(q0.size() > 0), 64'(1));
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("done0_cycle", 64'(cyc), 64'(e.cyc));
                check("result0", 64'(result0), 64'(e.res));
                check("err_cnt0", 64'(err0), 64'(e.err));
                check("pass0", 64'(pass0), 64'(e.pass));
            end
        end
        if (done1) begin
            check("done1_pending", 64'(q1.size() > 0), 64'(1));
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("done1_cycle", 64'(cyc), 64'(e.cyc));
                check("result1", 64'(result1), 64'(e.res));
                check("err_cnt1", 64'(err1), 64'(e.err));
                check("pass1", 64'(pass1), 64'(e.pass));
            end
        end
    end

    task automatic drain(input int lim);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("sweeps_completed", 64'(q0.size() + q1.size()), 64'(0));
    endtask

    task automatic idle_hold0(input int n, input logic [31:0] res);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_busy0", 64'(busy0), 64'(0));
            check("idle_result0", 64'(result0), 64'(res));
        end
    endtask

    // Full sweep on u0 with per-cycle vector/busy checks; optional stray starts.
    task automatic sweep0(input bit extra, input logic [31:0] res, input int err);
        int   k;
        exp_t e;
        @(negedge clk);
        start0 = 1'b1;
        k = cyc + 1;
        e.res = res; e.err = 6'(err); e.pass = (err == 0); e.cyc = k + 64;
        q0.push_back(e);
        for (int m = 0; m <= 64; m++) begin
            @(negedge clk);
            start0 = extra && ((m + 1 == 5) || (m + 1 == 20) || (m + 1 == 40));
            if (m < 64) begin
                check("sweep0_idx", 64'(idx0), 64'(m / 2));
                check("sweep0_busy", 64'(busy0), 64'(1));
            end else begin
                check("sweep0_busy_end", 64'(busy0), 64'(0));
            end
        end
        start0 = 1'b0;
        drain(10);
        idle_hold0(4, res);
    endtask

    initial begin
        int k;
        exp_t e;
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; y0_zero = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state held for 10 idle cycles.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rst_vec0", 64'(idx0), 64'(0));
            check("rst_busy0", 64'(busy0), 64'(0));
            check("rst_done0", 64'(done0), 64'(0));
            check("rst_result0", 64'(result0), 64'(0));
            check("rst_err0", 64'(err0), 64'(0));
            check("rst_pass0", 64'(pass0), 64'(0));
            check("rst_busy1", 64'(busy1), 64'(0));
        end

        // Matching block, then block stuck at 0 (16 ones in the golden table).
        sweep0(1'b0, 32'hF0F0_CCAA, 0);
        y0_zero = 1'b1;
        sweep0(1'b0, 32'h0000_0000, 16);
        y0_zero = 1'b0;

        // Stray starts mid-sweep must be ignored.
        sweep0(1'b1, 32'hF0F0_CCAA, 0);

        // Reset while idx==10 aborts without a done pulse.
        @(negedge clk);
        start0 = 1'b1;
        k = cyc + 1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_idx_before", 64'(idx0), 64'(10));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_vec", 64'(idx0), 64'(0));
        check("abort_busy", 64'(busy0), 64'(0));
        check("abort_result", 64'(result0), 64'(0));
        check("abort_err", 64'(err0), 64'(0));
        check("abort_cycle", 64'(cyc), 64'(k + 21));
        idle_hold0(70, 32'h0);
        sweep0(1'b0, 32'hF0F0_CCAA, 0);

        // Zero settle window: one vector per cycle.
        @(negedge clk);
        start1 = 1'b1;
        k = cyc + 1;
        e.res = EXP1; e.err = 6'd0; e.pass = 1'b1; e.cyc = k + 32;
        q1.push_back(e);
        for (int m = 0; m < 32; m++) begin
            @(negedge clk);
            start1 = 1'b0;
            check("sweep1_idx", 64'(idx1), 64'(m));
            check("sweep1_busy", 64'(busy1), 64'(1));
        end
        drain(10);
        @(negedge clk);
        check("sweep1_busy_end", 64'(busy1), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
